// File: rtl/cordic_pkg.sv
// Shared definitions for the cordic arbiter slice: latency, op encoding,
// FSM state type and the debug view of the arbiter's internal state.
package cordic_pkg;

    localparam int CORDIC_LATENCY = 25;

    localparam logic OP_ROT = 1'b0;
    localparam logic OP_VEC = 1'b1;

    // Angles are Q2.30 fixed point, so pi/4 = 32'h3243f6a8.
    localparam logic [31:0] ANGLE_PI_4 = 32'h3243f6a8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } cordic_state_t;

    typedef struct packed {
        cordic_state_t state;
        logic [2:0]    rr_ptr;
        logic [7:0]    cnt;
    } cordic_dbg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set valid bit at or after ptr,
// searching circularly, returned as one-hot grant plus encoded index.
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W:0] k;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (ID_W+1)'(ptr) + (ID_W+1)'(i);
            if (k >= (ID_W+1)'(N_REQ)) begin
                k = k - (ID_W+1)'(N_REQ);
            end
            if (!found && valid[k[ID_W-1:0]]) begin
                found               = 1'b1;
                grant[k[ID_W-1:0]]  = 1'b1;
                idx                 = k[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one cordic among N_REQ requesters: round-robin accept, one-cycle
// cordic start pulse, fixed iteration window, then a tagged response.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = CORDIC_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_op,
    input  logic [N_REQ-1:0]      req_x_signed,
    input  logic [N_REQ-1:0]      req_y_signed,
    input  logic [32*N_REQ-1:0]   req_x,
    input  logic [32*N_REQ-1:0]   req_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [32:0]           rsp_xn,
    output logic [32:0]           rsp_yn,
    output logic [31:0]           rsp_ri,
    output logic                  cd_req,
    output logic                  cd_op,
    output logic                  cd_x_signed,
    output logic                  cd_y_signed,
    output logic [31:0]           cd_x,
    output logic [31:0]           cd_y,
    input  logic [32:0]           cd_xn,
    input  logic [32:0]           cd_yn,
    input  logic [31:0]           cd_ri,
    output cordic_dbg_t           dbg
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    cordic_state_t    state, next_state;
    logic [ID_W-1:0]  rr_ptr, grant_idx, id_q;
    logic [N_REQ-1:0] grant;
    logic [CNT_W-1:0] cnt;
    logic             op_q, xs_q, ys_q;
    logic [31:0]      x_q, y_q;
    logic             any_valid;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign any_valid = |req_valid;

    // Handshakes: a transfer happens on any cycle where valid and ready are
    // both high; valid never waits on ready, and a requester holds valid and
    // its operands stable until it sees ready. The response side is the same.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        cd_req     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    req_ready  = grant;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cd_req     = 1'b1;
                next_state = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            op_q   <= 1'b0;
            xs_q   <= 1'b0;
            ys_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            id_q   <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        op_q   <= req_op[grant_idx];
                        xs_q   <= req_x_signed[grant_idx];
                        ys_q   <= req_y_signed[grant_idx];
                        x_q    <= req_x[{grant_idx, 5'd0} +: 32];
                        y_q    <= req_y[{grant_idx, 5'd0} +: 32];
                        id_q   <= grant_idx;
                        rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                ST_ISSUE: cnt <= CNT_W'(LATENCY);
                ST_BUSY:  cnt <= cnt - 1'b1;
                default:  ;
            endcase
        end
    end

    // Operands stay driven from the latched copy for the whole window since
    // the cordic re-reads op on every iteration.
    assign cd_op       = op_q;
    assign cd_x_signed = xs_q;
    assign cd_y_signed = ys_q;
    assign cd_x        = x_q;
    assign cd_y        = y_q;

    assign rsp_id = id_q;
    assign rsp_xn = cd_xn;
    assign rsp_yn = cd_yn;
    assign rsp_ri = cd_ri;

    assign dbg.state  = state;
    assign dbg.rr_ptr = 3'(rr_ptr);
    assign dbg.cnt    = 8'(cnt);

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one cordic datapath instance among N_REQ requesters.
- Each requester uses a valid/ready request handshake. The block arbitrates round-robin, sequences the cordic (one-cycle req pulse, then a fixed 25-cycle iteration window), and returns the result on a single valid/ready response channel tagged with the requester id.
- Sits between the cordic instance and its clients (e.g. the trig/atan issue logic); the cordic's ports are wired 1:1 to this block's cd_* ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must be ≥ clog2(N_REQ).
- LATENCY, 25, cycles after the cordic req edge until its outputs are final. Identical for op=0 (sin/cos) and op=1 (arctan).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_op  in  N_REQ  op per requester: 0 = rotate (sin/cos of angle x), 1 = vector (arctan of y/x)
- req_x_signed  in  N_REQ  x signedness flag
- req_y_signed  in  N_REQ  y signedness flag
- req_x  in  32*N_REQ  packed x operands; requester k at [32k+31:32k]
- req_y  in  32*N_REQ  packed y operands
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_id  out  ID_W  requester index owning the result
- rsp_xn  out  33  signed result x
- rsp_yn  out  33  signed result y
- rsp_ri  out  32  signed angle/residual result
- cd_req  out  1  cordic start pulse
- cd_op, cd_x_signed, cd_y_signed  out  1 each  to cordic
- cd_x, cd_y  out  32 each  to cordic
- cd_xn, cd_yn  in  33 each  from cordic
- cd_ri  in  32  from cordic

Behaviour:
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, cd_req=0, rr_ptr=0, cnt=0, operand/id registers=0. rsp_xn/yn/ri are don't-care while rsp_valid=0.
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - If any req_valid is set, grant g = the first set bit at or after rr_ptr (circular).
  - req_ready[g]=1 combinationally in the same cycle. The transfer occurs that cycle.
  - Latch op/x/y/signed flags and id=g. Set rr_ptr <= (g+1) mod N_REQ. Next state ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE:
  - cd_req=1 for exactly this cycle; cd_* operands driven from the latched registers.
  - cnt <= LATENCY. Next state BUSY.
- BUSY:
  - cnt decrements each cycle. When cnt==1, next state DONE. BUSY lasts exactly LATENCY cycles.
  - cd_req=0. cd_op is held stable, because the cordic reads op every iteration.
- DONE:
  - rsp_valid=1. rsp_xn/yn/ri pass through combinationally from cd_*; the cordic holds these outputs once its count reaches 0 and no req is seen.
  - rsp_id = latched id.
  - Stay in DONE until rsp_ready=1, then go to IDLE.
- Timing: request accept to rsp_valid = LATENCY+2 cycles. Back-to-back throughput is one op per LATENCY+3 cycles.
- req_ready is 0 in every state except IDLE. A new request is never accepted while a result is pending.
- Simultaneous valids: only one requester is granted per IDLE cycle. Losers keep valid asserted; their operands must stay stable until they receive ready.
- rr_ptr wrap-around: pointer at N_REQ-1 with only requester 0 valid grants 0. Pointer then becomes 1.
- Reset mid-operation (any state): return to reset values next cycle. The cordic keeps iterating internally, but its result is discarded. The next ISSUE reloads it via cd_req.
- The cordic has no reset. Its state is never observed before the block's first cd_req.

Decomposition:
- Shared package cordic_pkg:
  - CORDIC_LATENCY=25
  - op encoding constants OP_ROT=0, OP_VEC=1
  - FSM state enum
  - fixed-point scaling note: angle Q2.30, pi/4 = 32'h3243f6a8
- One sub-module: rr_arbiter (N_REQ parameter).
  - Inputs: valid vector, pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.

Test Plan:
- Single vector op: req 0, op=1, x=y=32'h20000000 -> req_ready[0] in the same cycle; cd_req exactly 2nd cycle; rsp_valid on cycle 27 after accept; rsp_id=0; rsp_ri within ±8 LSB of 32'h3243f6a8.
- Single rotate op: req 2, op=0, x=0, y=0 -> rsp_xn within ±16 of 32'h40000000, rsp_yn within ±16 of 0, rsp_id=2.
- All four requesters valid continuously -> grants in order 0,1,2,3,0; each result carries the matching id; no requester is starved.
- Back-pressure: rsp_ready held 0 for 10 cycles in DONE -> rsp_valid and outputs stable; req_ready stays 0; accept resumes on the cycle after rsp_ready=1.
- Reset asserted in BUSY at cnt=12 -> next cycle rsp_valid=0, req_ready=0, state IDLE; a following request completes correctly with normal latency.
- rr_ptr wrap: rr_ptr=3, only req 0 valid -> grant 0; rr_ptr becomes 1.
